// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared types and constants for the rv32i hazard unit
package rv32i_pkg;

    // Forward select encodings for an EXEC operand
    localparam int FWD_SEL_RF  = 0;
    localparam int FWD_SEL_MEM = 1;
    localparam int FWD_SEL_WB  = 2;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } inflight_entry_t;

    // True when an in-flight entry produces a register a decoded operand reads.
    // x0 is never a real producer.
    function automatic logic src_match(inflight_entry_t e, logic [4:0] rs, logic used);
        return used && e.valid && e.we && (e.rd != 5'd0) && (e.rd == rs);
    endfunction

endpackage

// File: rtl/rv32i_hazard_unit_if.sv
// rtl/rv32i_hazard_unit_if.sv - decode-side and control outputs bundle of the hazard unit
interface rv32i_hazard_unit_if #(
    parameter int NB_STAGES = 3,
    parameter int CNT_W     = 32
);
    localparam int SEL_W = (NB_STAGES > 1) ? $clog2(NB_STAGES) : 1;

    logic             dec_valid_i;
    logic [4:0]       dec_rs1_i;
    logic [4:0]       dec_rs2_i;
    logic             dec_rs1_used_i;
    logic             dec_rs2_used_i;
    logic [4:0]       dec_rd_i;
    logic             dec_rd_we_i;
    logic             dec_is_load_i;
    logic             dec_is_jump_i;
    logic             branch_taken_i;

    logic             stall_o;
    logic             flush_o;
    logic             fetch_kill_o;
    logic             issue_o;
    logic [SEL_W-1:0] fwd_rs1_sel_o;
    logic [SEL_W-1:0] fwd_rs2_sel_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Control path side: presents the decoded instruction, consumes hazard decisions
    modport master (
        output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs1_used_i, dec_rs2_used_i,
        output dec_rd_i, dec_rd_we_i, dec_is_load_i, dec_is_jump_i, branch_taken_i,
        input  stall_o, flush_o, fetch_kill_o, issue_o,
        input  fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o, flush_cnt_o
    );

    // Hazard unit side
    modport slave (
        input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs1_used_i, dec_rs2_used_i,
        input  dec_rd_i, dec_rd_we_i, dec_is_load_i, dec_is_jump_i, branch_taken_i,
        output stall_o, flush_o, fetch_kill_o, issue_o,
        output fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o, flush_cnt_o
    );

endinterface

// File: rtl/rv32i_inflight_tracker.sv
// rtl/rv32i_inflight_tracker.sv - shift table of destination registers of in-flight instructions
module rv32i_inflight_tracker
    import rv32i_pkg::*;
#(
    parameter int NB_STAGES = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            insert_i,
    input  inflight_entry_t                 new_entry_i,
    output inflight_entry_t [NB_STAGES-1:0] entries_o
);

    inflight_entry_t [NB_STAGES-1:0] tbl;

    // Entry 0 takes the issuing instruction or a bubble; older entries advance one stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tbl <= '0;
        end else begin
            tbl[0] <= insert_i ? new_entry_i : '0;
            for (int k = 1; k < NB_STAGES; k++) begin
                tbl[k] <= tbl[k-1];
            end
        end
    end

    assign entries_o = tbl;

endmodule

// File: rtl/rv32i_hazard_unit.sv
// rtl/rv32i_hazard_unit.sv - RAW hazard detection, forwarding selects, flush and perf counters
module rv32i_hazard_unit
    import rv32i_pkg::*;
#(
    parameter int NB_STAGES      = 3,
    parameter int FWD_EN         = 1,
    parameter int LOAD_READY_IDX = 2,
    parameter int CNT_W          = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rv32i_hazard_unit_if.slave   hz
);

    localparam int SEL_W = (NB_STAGES > 1) ? $clog2(NB_STAGES) : 1;

    inflight_entry_t [NB_STAGES-1:0] entries;
    inflight_entry_t                 new_entry;

    logic             rs1_hit, rs2_hit;
    logic             rs1_load, rs2_load;
    logic [SEL_W-1:0] rs1_k, rs2_k;
    logic [SEL_W:0]   rs1_res, rs2_res;
    logic             hazard;
    logic             stall, flush, issue, kill;

    logic [SEL_W-1:0] rs1_sel_q, rs2_sel_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Returns {hazard, select} for the youngest producer of one operand.
    // A match in the last stage is covered by the write-through register file.
    function automatic logic [SEL_W:0] resolve_operand(logic hit, logic [SEL_W-1:0] k,
                                                       logic is_load);
        logic             hz_bit;
        logic [SEL_W-1:0] sel;
        hz_bit = 1'b0;
        sel    = SEL_W'(FWD_SEL_RF);
        if (hit && (int'(k) < NB_STAGES - 1)) begin
            if (FWD_EN == 0) begin
                hz_bit = 1'b1;
            end else if (is_load && (int'(k) + 1 < LOAD_READY_IDX)) begin
                hz_bit = 1'b1;
            end else begin
                sel = k + SEL_W'(1);
            end
        end
        return {hz_bit, sel};
    endfunction

    assign new_entry = '{valid:   1'b1,
                         rd:      hz.dec_rd_i,
                         we:      hz.dec_rd_we_i,
                         is_load: hz.dec_is_load_i};

    rv32i_inflight_tracker #(
        .NB_STAGES (NB_STAGES)
    ) u_tracker (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .insert_i    (issue),
        .new_entry_i (new_entry),
        .entries_o   (entries)
    );

    // Youngest-match search: scanning oldest to youngest lets the lowest index win
    always_comb begin
        rs1_hit  = 1'b0;
        rs2_hit  = 1'b0;
        rs1_load = 1'b0;
        rs2_load = 1'b0;
        rs1_k    = '0;
        rs2_k    = '0;
        for (int k = NB_STAGES - 1; k >= 0; k--) begin
            if (src_match(entries[k], hz.dec_rs1_i, hz.dec_rs1_used_i)) begin
                rs1_hit  = 1'b1;
                rs1_k    = k[SEL_W-1:0];
                rs1_load = entries[k].is_load;
            end
            if (src_match(entries[k], hz.dec_rs2_i, hz.dec_rs2_used_i)) begin
                rs2_hit  = 1'b1;
                rs2_k    = k[SEL_W-1:0];
                rs2_load = entries[k].is_load;
            end
        end
    end

    // Pipeline control decisions; a taken branch wins over any stall, reset silences all
    always_comb begin
        rs1_res = resolve_operand(rs1_hit, rs1_k, rs1_load);
        rs2_res = resolve_operand(rs2_hit, rs2_k, rs2_load);
        hazard  = rs1_res[SEL_W] | rs2_res[SEL_W];
        flush   = ~rst_i & hz.branch_taken_i;
        stall   = ~rst_i & hz.dec_valid_i & hazard & ~hz.branch_taken_i;
        issue   = ~rst_i & hz.dec_valid_i & ~stall & ~flush;
        kill    = ~rst_i & hz.dec_valid_i & hz.dec_is_jump_i & ~stall & ~flush;
    end

    // Forward selects follow the issuing instruction into EXEC; bubbles read the register file
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs1_sel_q <= '0;
            rs2_sel_q <= '0;
        end else if (issue) begin
            rs1_sel_q <= rs1_res[SEL_W-1:0];
            rs2_sel_q <= rs2_res[SEL_W-1:0];
        end else begin
            rs1_sel_q <= '0;
            rs2_sel_q <= '0;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_o       = stall;
    assign hz.flush_o       = flush;
    assign hz.issue_o       = issue;
    assign hz.fetch_kill_o  = kill;
    assign hz.fwd_rs1_sel_o = rs1_sel_q;
    assign hz.fwd_rs2_sel_o = rs2_sel_q;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// tb/tb_rv32i_hazard_unit.sv - directed self-checking bench for rv32i_hazard_unit
module tb_rv32i_hazard_unit;
    import rv32i_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    rv32i_hazard_unit_if #(.NB_STAGES(3), .CNT_W(32)) ha ();
    rv32i_hazard_unit_if #(.NB_STAGES(3), .CNT_W(2))  hb ();

    rv32i_hazard_unit #(
        .NB_STAGES(3), .FWD_EN(1), .LOAD_READY_IDX(2), .CNT_W(32)
    ) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (ha.slave)
    );

    rv32i_hazard_unit #(
        .NB_STAGES(3), .FWD_EN(0), .LOAD_READY_IDX(2), .CNT_W(2)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // which=0 drives instance A (forwarding), which=1 drives instance B (stall-only)
    task automatic ins(input bit which, input logic v,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we,
                       input logic ld, input logic jmp, input logic br);
        if (!which) begin
            ha.dec_valid_i = v;   ha.dec_rs1_i = rs1;  ha.dec_rs1_used_i = u1;
            ha.dec_rs2_i = rs2;   ha.dec_rs2_used_i = u2;
            ha.dec_rd_i = rd;     ha.dec_rd_we_i = we; ha.dec_is_load_i = ld;
            ha.dec_is_jump_i = jmp; ha.branch_taken_i = br;
        end else begin
            hb.dec_valid_i = v;   hb.dec_rs1_i = rs1;  hb.dec_rs1_used_i = u1;
            hb.dec_rs2_i = rs2;   hb.dec_rs2_used_i = u2;
            hb.dec_rd_i = rd;     hb.dec_rd_we_i = we; hb.dec_is_load_i = ld;
            hb.dec_is_jump_i = jmp; hb.branch_taken_i = br;
        end
    endtask

    task automatic idle(input bit which, input int n);
        ins(which, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // valid jump with a taken branch while in reset: everything stays quiet
        ins(0, 1, 1, 1, 2, 1, 3, 1, 0, 1, 1);
        @(posedge clk);
        #2;
        check("rst_stall", ha.stall_o, 0);
        check("rst_flush", ha.flush_o, 0);
        check("rst_issue", ha.issue_o, 0);
        check("rst_kill",  ha.fetch_kill_o, 0);
        tick();
        check("rst_sel1",  ha.fwd_rs1_sel_o, 0);
        check("rst_scnt",  ha.stall_cnt_o, 0);
        check("rst_fcnt",  ha.flush_cnt_o, 0);
        check("rst_b_scnt", hb.stall_cnt_o, 0);
        idle(0, 0);
        rst = 1'b0;
        tick();

        // addi x5,x0,1 ; add x6,x5,x0 -> forward from EXEC result
        ins(0, 1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        #1;
        check("t1_addi_issue", ha.issue_o, 1);
        tick();
        check("t1_addi_sel1", ha.fwd_rs1_sel_o, FWD_SEL_RF);
        ins(0, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
        #1;
        check("t1_add_stall", ha.stall_o, 0);
        check("t1_add_issue", ha.issue_o, 1);
        tick();
        check("t1_add_sel1", ha.fwd_rs1_sel_o, FWD_SEL_MEM);
        check("t1_add_sel2", ha.fwd_rs2_sel_o, FWD_SEL_RF);
        idle(0, 1);
        check("t1_idle_sel1", ha.fwd_rs1_sel_o, 0);
        idle(0, 3);

        // lw x5,0(x1) ; add x7,x5,x5 -> one load-use stall, then forward from WB
        ins(0, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
        #1;
        check("t2_lw_issue", ha.issue_o, 1);
        tick();
        ins(0, 1, 5, 1, 5, 1, 7, 1, 0, 0, 0);
        #1;
        check("t2_use_stall", ha.stall_o, 1);
        check("t2_use_issue0", ha.issue_o, 0);
        tick();
        check("t2_bubble_sel1", ha.fwd_rs1_sel_o, 0);
        check("t2_scnt1", ha.stall_cnt_o, 1);
        check("t2_retry_stall", ha.stall_o, 0);
        check("t2_retry_issue", ha.issue_o, 1);
        tick();
        check("t2_sel1", ha.fwd_rs1_sel_o, FWD_SEL_WB);
        check("t2_sel2", ha.fwd_rs2_sel_o, FWD_SEL_WB);
        check("t2_scnt_hold", ha.stall_cnt_o, 1);
        idle(0, 3);

        // addi x0,x1,1 ; add x3,x0,x0 -> x0 is never a dependency
        ins(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        tick();
        ins(0, 1, 0, 1, 0, 1, 3, 1, 0, 0, 0);
        #1;
        check("t4_x0_stall", ha.stall_o, 0);
        tick();
        check("t4_x0_sel1", ha.fwd_rs1_sel_o, 0);
        check("t4_x0_sel2", ha.fwd_rs2_sel_o, 0);
        idle(0, 3);

        // jal x1 ; add x2,x1,x1 -> fetch kill on the jump, link value forwarded
        ins(0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
        #1;
        check("tj_kill", ha.fetch_kill_o, 1);
        check("tj_issue", ha.issue_o, 1);
        tick();
        ins(0, 1, 1, 1, 1, 1, 2, 1, 0, 0, 0);
        #1;
        check("tj_next_kill", ha.fetch_kill_o, 0);
        tick();
        check("tj_sel1", ha.fwd_rs1_sel_o, FWD_SEL_MEM);
        check("tj_sel2", ha.fwd_rs2_sel_o, FWD_SEL_MEM);
        idle(0, 3);

        // lw x9 ; add x10,x9,x0 stalls, then a taken branch flushes the stalled slot
        ins(0, 1, 0, 1, 0, 0, 9, 1, 1, 0, 0);
        tick();
        ins(0, 1, 9, 1, 0, 1, 10, 1, 0, 0, 0);
        #1;
        check("t5_stall", ha.stall_o, 1);
        tick();
        ins(0, 1, 9, 1, 0, 1, 10, 1, 0, 1, 1);
        #1;
        check("t5_fl_stall", ha.stall_o, 0);
        check("t5_fl_flush", ha.flush_o, 1);
        check("t5_fl_issue", ha.issue_o, 0);
        check("t5_fl_kill",  ha.fetch_kill_o, 0);
        tick();
        check("t5_fcnt", ha.flush_cnt_o, 1);
        check("t5_scnt", ha.stall_cnt_o, 2);
        check("t5_entry0", dut_a.entries[0].valid, 0);
        check("t5_sel1", ha.fwd_rs1_sel_o, 0);
        idle(0, 3);

        // three loads in flight, then reset drops them all
        ins(0, 1, 0, 1, 0, 0, 11, 1, 1, 0, 0);
        tick();
        ins(0, 1, 0, 1, 0, 0, 12, 1, 1, 0, 0);
        tick();
        ins(0, 1, 0, 1, 0, 0, 13, 1, 1, 0, 0);
        tick();
        idle(0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_scnt", ha.stall_cnt_o, 0);
        check("t6_fcnt", ha.flush_cnt_o, 0);
        ins(0, 1, 13, 1, 12, 1, 14, 1, 0, 0, 0);
        #1;
        check("t6_dep_stall", ha.stall_o, 0);
        check("t6_dep_issue", ha.issue_o, 1);
        tick();
        check("t6_sel1", ha.fwd_rs1_sel_o, 0);
        check("t6_sel2", ha.fwd_rs2_sel_o, 0);
        idle(0, 1);

        // stall-only instance: addi x5 ; sub x6,x5,x1 -> two stall cycles, issue on third
        ins(1, 1, 0, 1, 0, 0, 5, 1, 0, 0, 0);
        #1;
        check("b_addi_issue", hb.issue_o, 1);
        tick();
        ins(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
        #1;
        check("b_stall_c1", hb.stall_o, 1);
        tick();
        check("b_stall_c2", hb.stall_o, 1);
        tick();
        check("b_stall_c3", hb.stall_o, 0);
        check("b_issue_c3", hb.issue_o, 1);
        tick();
        check("b_sel1", hb.fwd_rs1_sel_o, 0);
        check("b_sel2", hb.fwd_rs2_sel_o, 0);
        check("b_scnt2", hb.stall_cnt_o, 2);

        // 2-bit flush counter saturates at 3
        ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("b_fcnt1", hb.flush_cnt_o, 1);
        tick();
        tick();
        check("b_fcnt3", hb.flush_cnt_o, 3);
        tick();
        check("b_fcnt_sat", hb.flush_cnt_o, 3);
        idle(1, 3);

        // 2-bit stall counter saturates at 3
        ins(1, 1, 0, 1, 0, 0, 7, 1, 0, 0, 0);
        tick();
        ins(1, 1, 7, 1, 0, 0, 8, 1, 0, 0, 0);
        tick();
        check("b_scnt3", hb.stall_cnt_o, 3);
        tick();
        check("b_scnt_sat", hb.stall_cnt_o, 3);
        check("b_issue_after", hb.issue_o, 1);
        idle(1, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
